// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Multi-cycle shift-and-add multiplier that borrows the core's shared
// single-cycle ALU. In IDLE and DONE the core's ALU operands and control pass
// straight through. During a run the sequencer owns the ALU, alternates
// ADD (3'b000) and SLL (3'b100) steps WIDTH times, and raises stall so the
// core freezes. The product is the low WIDTH bits of op_a * op_b. These low
// bits are the same for signed and unsigned operands.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   start             multiply request, sampled only in IDLE
//   op_a, op_b        multiplicand / multiplier, captured when start is accepted
//   core_src_a/b      core ALU operands (pass-through when idle)
//   core_alu_control  core ALU op (pass-through when idle)
//   alu_result        result returned by the shared ALU
//   alu_src_a/b       operands driven to the ALU
//   alu_control       op driven to the ALU
//   busy, stall       high in ADD, SHIFT and DONE
//   done              one-cycle pulse; product is valid
//   product           result register; holds between runs
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] core_src_a,
  input  logic [WIDTH-1:0] core_src_b,
  input  logic [2:0]       core_alu_control,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [2:0]       alu_control,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [CW-1:0]    count_q,   count_d;
  logic [WIDTH-1:0] product_q, product_d;

  // NOTE: every flop uses non-blocking assignment, so all registers update
  // together from the same pre-edge values no matter the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case. Without these,
    // a path that skips an assignment would infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    product_d   = product_q;
    alu_src_a   = core_src_a;
    alu_src_b   = core_src_b;
    alu_control = core_alu_control;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          count_d  = '0;
          state_d  = ADD;
        end
      end

      ADD: begin
        // The add is issued even when the multiplier bit is 0, adding zero.
        // This keeps the latency fixed for every operand.
        alu_control = ALU_ADD;
        alu_src_a   = acc_q;
        alu_src_b   = mplier_q[0] ? mcand_q : '0;
        acc_d       = alu_result;
        state_d     = SHIFT;
      end

      SHIFT: begin
        alu_control = ALU_SLL;
        alu_src_a   = mcand_q;
        alu_src_b   = WIDTH'(1);
        mcand_d     = alu_result;
        mplier_d    = mplier_q >> 1;
        if (count_q == LAST_STEP) begin
          // acc already holds the sum from the final ADD step.
          product_d = acc_q;
          state_d   = DONE;
        end else begin
          count_d = count_q + CW'(1);
          state_d = ADD;
        end
      end

      DONE: begin
        // The ALU is back on core pass-through. start is ignored here.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign stall   = busy;
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Randomized self-checking bench for alu_mul_sequencer. A behavioural ALU
// closes the loop. A reference model tracks the run as a step number from
// 1 to 2*WIDTH+1. From that step it computes every ALU port value with plain
// arithmetic, using partial products of the captured operands. A compare
// process checks the outputs at every falling edge. Directed scenarios also
// pin literal products and the cycle timing.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [W-1:0] core_src_a = '0, core_src_b = '0;
  logic [2:0]   core_alu_control = 3'b000;
  logic [W-1:0] alu_result;
  logic [W-1:0] alu_src_a, alu_src_b;
  logic [2:0]   alu_control;
  logic         busy, stall, done;
  logic [W-1:0] product;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  bit rand_core = 1'b0;

  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op_a             (op_a),
    .op_b             (op_b),
    .core_src_a       (core_src_a),
    .core_src_b       (core_src_b),
    .core_alu_control (core_alu_control),
    .alu_result       (alu_result),
    .alu_src_a        (alu_src_a),
    .alu_src_b        (alu_src_b),
    .alu_control      (alu_control),
    .busy             (busy),
    .stall            (stall),
    .done             (done),
    .product          (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural shared ALU.
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_src_a + alu_src_b;
      3'b001:  alu_result = alu_src_a - alu_src_b;
      3'b100:  alu_result = alu_src_a << alu_src_b[4:0];
      default: alu_result = alu_src_a & alu_src_b;
    endcase
  end

  // Random core traffic, which the design must ignore while it is busy.
  always @(posedge clk) begin
    if (rand_core) begin
      #3;
      core_src_a       = $urandom;
      core_src_b       = $urandom;
      core_alu_control = 3'($urandom_range(7, 0));
    end
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // step 0 means idle. Steps 1..2W are the ALU steps: odd steps add, even
  // steps shift. Step 2W+1 is the done cycle.
  int           step = 0;
  logic [W-1:0] ma = '0, mb = '0, last_prod = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      step      = 0;
      last_prod = '0;
    end else if (step == 0) begin
      if (start) begin
        step = 1;
        ma   = op_a;
        mb   = op_b;
      end
    end else if (step == 2*W) begin
      step      = 2*W + 1;
      last_prod = ma * mb;
    end else if (step == 2*W + 1) begin
      step = 0;
    end else begin
      step++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int           k;
    logic [W-1:0] mask, exp_a, exp_b;
    logic [2:0]   exp_c;
    logic         exp_busy;
    exp_busy = (step != 0);
    check("busy",  W'(busy),  W'(exp_busy));
    check("stall", W'(stall), W'(exp_busy));
    check("done",  W'(done),  W'(step == 2*W + 1));
    if (step == 0 || step == 2*W + 1) begin
      exp_a = core_src_a;
      exp_b = core_src_b;
      exp_c = core_alu_control;
      check("product_hold", product, last_prod);
    end else begin
      k = (step - 1) / 2;
      if (step % 2 == 1) begin
        // The accumulator holds a times the low k bits of b.
        mask  = (k == 0) ? '0 : ({W{1'b1}} >> (W - k));
        exp_a = ma * (mb & mask);
        exp_b = mb[k] ? (ma << k) : '0;
        exp_c = 3'b000;
      end else begin
        exp_a = ma << k;
        exp_b = W'(1);
        exp_c = 3'b100;
      end
    end
    check("alu_src_a",   alu_src_a,       exp_a);
    check("alu_src_b",   alu_src_b,       exp_b);
    check("alu_control", W'(alu_control), W'(exp_c));
  end

  // ---------------- stimulus helpers ----------------
  // Starts one multiply and waits for done (bounded). If interfere_at >= 0,
  // start is pulsed again with other operands that many cycles into the run.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int interfere_at,
                         output logic [W-1:0] prod, output int busy_cycles);
    bit got;
    @(posedge clk); #2;
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    busy_cycles = 0;
    got  = 1'b0;
    prod = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        got  = 1'b1;
        prod = product;
        break;
      end
      if (i == interfere_at) begin
        #1;
        op_a = 32'd1234; op_b = 32'd99; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    logic [W-1:0] p, ra, rb;
    int           bc, t_first, t_second;
    bit           got;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy",    W'(busy),  32'd0);
    check("rst_done",    W'(done),  32'd0);
    check("rst_product", product,   32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Idle pass-through.
    core_alu_control = 3'b001; core_src_a = 32'd10; core_src_b = 32'd4;
    @(negedge clk);
    check("pt_control", W'(alu_control), 32'd1);
    check("pt_src_a",   alu_src_a,       32'd10);
    check("pt_src_b",   alu_src_b,       32'd4);
    check("pt_stall",   W'(stall),       32'd0);
    check("pt_result",  alu_result,      32'd6);

    rand_core = 1'b1;

    // 7 x 6, with the busy window length.
    run_mul(32'd7, 32'd6, -1, p, bc);
    check("p_7x6", p, 32'd42);
    check("busy_cycles", 32'(bc), 32'd65);
    wait_idle();

    // -1 x 3, with an ignored start at cycle 10.
    run_mul(32'hFFFF_FFFF, 32'd3, 9, p, bc);
    check("p_neg1x3", p, 32'hFFFF_FFFD);
    wait_idle();

    // Overflow wraps.
    run_mul(32'h0001_0000, 32'h0001_0000, -1, p, bc);
    check("p_wrap", p, 32'd0);
    wait_idle();

    // Asynchronous reset in the middle of a clock period, mid-run.
    @(posedge clk); #2;
    op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_busy",    W'(busy), 32'd0);
    check("arst_done",    W'(done), 32'd0);
    check("arst_product", product,  32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    run_mul(32'd5, 32'd5, -1, p, bc);
    check("p_5x5", p, 32'd25);
    check("busy_cycles_5x5", 32'(bc), 32'd65);
    wait_idle();

    // start held high: done repeats every 66 cycles.
    @(posedge clk); #2;
    op_a = 32'd3; op_b = 32'd4; start = 1'b1;
    t_first = 0; t_second = 0;
    for (int n = 0; n < 2; n++) begin
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (done) begin got = 1'b1; break; end
      end
      if (!got) check("cont_timeout", 32'd0, 32'd1);
      check("p_cont", product, 32'd12);
      if (n == 0) t_first = cyc; else t_second = cyc;
    end
    check("cont_period", 32'(t_second - t_first), 32'd66);
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();

    // Random operands.
    for (int n = 0; n < 8; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n == 0) rb = '0;
      run_mul(ra, rb, (n % 2 == 1) ? int'($urandom_range(40, 0)) : -1, p, bc);
      check("p_random", p, ra * rb);
      wait_idle();
    end

    rand_core = 1'b0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
